// File: rtl/packer_pkg.sv
// Shared types and constants for the compressed line packer: code/length widths,
// chunk and staging-buffer sizes, and the packer FSM state encoding.
package packer_pkg;

  localparam int IN_W  = 68;
  localparam int LEN_W = 7;
  localparam int CHUNK = 128;
  localparam int CNT_W = 8;
  localparam int BUF_W = 2 * CHUNK;
  localparam int LB_W  = 10;

  localparam logic [CNT_W-1:0] CHUNK_CNT = CNT_W'(CHUNK);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Lengths beyond the code width are illegal; clamp them so the fill never overshoots.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : len;
  endfunction

endpackage

// File: rtl/packer_insert.sv
// Combinational insert path: keeps only the low len bits of a code and places them
// at bit position fill of a staging-buffer-wide vector.
module packer_insert
  import packer_pkg::*;
(
  input  logic [IN_W-1:0]  data,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] fill,
  output logic [BUF_W-1:0] ins
);

  logic [IN_W-1:0] mask;

  always_comb begin
    mask = (len >= LEN_W'(IN_W)) ? '1 : ~({IN_W{1'b1}} << len);
    ins  = {{(BUF_W-IN_W){1'b0}}, data & mask} << fill;
  end

endmodule

// File: rtl/compressed_line_packer.sv
// Packs variable-length codes LSB-first into 128-bit chunks, flushing each cache line
// zero-padded. Define PACKER_LINE_LEN_EN to report the line's bit total on o_line_bits.
module compressed_line_packer
  import packer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IN_W-1:0]   i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CHUNK-1:0]  o_data,
  output logic              o_last,
  output logic [LB_W-1:0]   o_line_bits,
  output logic [1:0]        o_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender keeps valid and its payload steady until then. Input and output sides
  // are never ready/valid together, so a beat cannot enter during a chunk transfer.

  state_t             state, state_nxt;
  logic [BUF_W-1:0]   buf_q, buf_nxt, ins;
  logic [CNT_W-1:0]   fill_q, fill_nxt;
  logic [LEN_W-1:0]   len_sat;
  logic               accept, pop;

  assign len_sat = sat_len(i_len);

  packer_insert u_insert (
    .data (i_data),
    .len  (len_sat),
    .fill (fill_q),
    .ins  (ins)
  );

  always_comb begin
    state_nxt = state;
    buf_nxt   = buf_q;
    fill_nxt  = fill_q;
    o_ready   = (state == ACCUM);
    o_valid   = (state != ACCUM);
    o_last    = (state == FLUSH) && (fill_q <= CHUNK_CNT);
    accept    = o_ready && i_valid;
    pop       = o_valid && i_ready;
    case (state)
      ACCUM: begin
        if (accept) begin
          buf_nxt  = buf_q | ins;
          fill_nxt = fill_q + CNT_W'(len_sat);
          if (i_last) begin
            state_nxt = FLUSH;
          end else if (fill_nxt >= CHUNK_CNT) begin
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        if (pop) begin
          buf_nxt   = buf_q >> CHUNK;
          fill_nxt  = fill_q - CHUNK_CNT;
          state_nxt = ACCUM;
        end
      end
      FLUSH: begin
        if (pop) begin
          if (o_last) begin
            buf_nxt   = '0;
            fill_nxt  = '0;
            state_nxt = ACCUM;
          end else begin
            buf_nxt  = buf_q >> CHUNK;
            fill_nxt = fill_q - CHUNK_CNT;
          end
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state  <= ACCUM;
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      state  <= state_nxt;
      buf_q  <= buf_nxt;
      fill_q <= fill_nxt;
    end
  end

  assign o_data  = buf_q[CHUNK-1:0];
  assign o_state = state;

`ifdef PACKER_LINE_LEN_EN
  logic [LB_W-1:0] line_q, line_nxt;

  always_comb begin
    line_nxt = line_q;
    if (accept) begin
      line_nxt = line_q + LB_W'(len_sat);
    end else if (pop && o_last) begin
      line_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_nxt;
    end
  end

  assign o_line_bits = o_last ? line_q : '0;
`else
  assign o_line_bits = '0;
`endif

endmodule

// File: tb/tb_compressed_line_packer.sv
// Bench for compressed_line_packer: directed lines plus random traffic, checked
// against a bit-queue model of each cache line.
module tb_compressed_line_packer;
  import packer_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_valid;
  logic              o_ready;
  logic [IN_W-1:0]   i_data;
  logic [LEN_W-1:0]  i_len;
  logic              i_last;
  logic              o_valid;
  logic              i_ready;
  logic [CHUNK-1:0]  o_data;
  logic              o_last;
  logic [LB_W-1:0]   o_line_bits;
  logic [1:0]        o_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [IN_W-1:0]  data;
    logic [LEN_W-1:0] len;
    logic             last;
  } beat_t;

  beat_t            beat_q[$];
  logic [CHUNK-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [LB_W-1:0]  exp_lb_q[$];
  bit               model_bits[$];
  int               model_total;
  logic [CHUNK-1:0] last_chunk;

  compressed_line_packer dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_len       (i_len),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_line_bits (o_line_bits),
    .o_state     (o_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rand68();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[IN_W-1:0];
  endfunction

  // reference model: one bit queue per line, chunks are consecutive 128-bit slices
  function automatic void push_exp(input logic is_last);
    logic [CHUNK-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (model_bits.size() > 0) c[i] = model_bits.pop_front();
    end
    exp_q.push_back(c);
    exp_last_q.push_back(is_last);
`ifdef PACKER_LINE_LEN_EN
    exp_lb_q.push_back(is_last ? LB_W'(model_total) : '0);
`else
    exp_lb_q.push_back('0);
`endif
  endfunction

  function automatic void model_accept(input beat_t b);
    int l;
    l = (int'(b.len) > IN_W) ? IN_W : int'(b.len);
    for (int i = 0; i < l; i++) model_bits.push_back(b.data[i]);
    model_total += l;
    if (!b.last) begin
      if (model_bits.size() >= CHUNK) push_exp(1'b0);
    end else begin
      while (model_bits.size() > CHUNK) push_exp(1'b0);
      push_exp(1'b1);
      model_total = 0;
    end
  endfunction

  // driver tasks
  task automatic add_beat(input logic [IN_W-1:0] d, input int len, input logic last);
    beat_t b;
    b.data = d;
    b.len  = LEN_W'(len);
    b.last = last;
    beat_q.push_back(b);
  endtask

  task automatic add_rand_line();
    int nb, len;
    nb = $urandom_range(8, 1);
    for (int k = 0; k < nb; k++) begin
      len = ($urandom_range(9, 0) == 0) ? $urandom_range(127, 69) : $urandom_range(68, 0);
      add_beat(rand68(), len, k == nb - 1);
    end
  endtask

  // Entered and left at posedge+1; inputs set here are sampled at the next edge.
  task automatic run(input int valid_pct, input int ready_pct, input int stall);
    int               cycles;
    int               stall_left;
    bit               presenting;
    bit               prev_hold;
    logic [CHUNK-1:0] prev_data;
    logic             prev_last;
    cycles     = 0;
    stall_left = stall;
    presenting = 0;
    prev_hold  = 0;
    prev_data  = '0;
    prev_last  = 0;
    while ((beat_q.size() > 0 || exp_q.size() > 0) && cycles < 4000) begin
      if (prev_hold) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, prev_data);
        check("hold_last", o_last, prev_last);
        check("hold_ready", o_ready, 0);
      end
      if (!presenting && beat_q.size() > 0 && $urandom_range(99, 0) < valid_pct) presenting = 1;
      if (presenting) begin
        i_valid = 1;
        i_data  = beat_q[0].data;
        i_len   = beat_q[0].len;
        i_last  = beat_q[0].last;
      end else begin
        i_valid = 0;
        i_data  = rand68();
        i_len   = LEN_W'($urandom_range(127, 0));
        i_last  = 1'($urandom_range(1, 0));
      end
      if (o_valid && stall_left > 0) begin
        i_ready = 0;
        stall_left--;
      end else begin
        i_ready = ($urandom_range(99, 0) < ready_pct);
      end
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
      prev_last = o_last;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_chunk", 1, 0);
        end else begin
          check("chunk_data", o_data, exp_q.pop_front());
          check("chunk_last", o_last, exp_last_q.pop_front());
          check("chunk_line_bits", o_line_bits, exp_lb_q.pop_front());
          last_chunk = o_data;
        end
      end
      if (i_valid && o_ready) begin
        model_accept(beat_q.pop_front());
        presenting = 0;
      end
      @(posedge i_clk);
      #1;
      cycles++;
    end
    i_valid = 0;
    i_ready = 0;
    check("run_budget", cycles < 4000, 1);
    check("leftover_chunks", exp_q.size(), 0);
  endtask

  task automatic push_beat(input logic [IN_W-1:0] d, input int len, input logic last);
    i_data  = d;
    i_len   = LEN_W'(len);
    i_last  = last;
    i_valid = 1;
    for (int w = 0; w < 50 && !o_ready; w++) begin
      @(posedge i_clk);
      #1;
    end
    check("push_ready", o_ready, 1);
    @(posedge i_clk);
    #1;
    i_valid = 0;
  endtask

  logic [33:0]      pa, pb, pc, pd;
  logic [CHUNK-1:0] exp1;

  initial begin
    i_reset = 0;
    i_valid = 0;
    i_ready = 0;
    i_data  = '0;
    i_len   = '0;
    i_last  = 0;
    model_total = 0;
    last_chunk  = '0;
    #12;
    check("reset_ready", o_ready, 1);
    check("reset_valid", o_valid, 0);
    check("reset_data", o_data, 0);
    check("reset_last", o_last, 0);
    check("reset_line_bits", o_line_bits, 0);
    check("reset_state", o_state, ACCUM);
    i_reset = 1;
    @(posedge i_clk);
    #1;

    // four 34-bit codes fill exactly one chunk plus 8 residual bits
    pa = 34'h123456789;
    pb = 34'h3FEDCBA98;
    pc = 34'h0F0F0F0F0;
    pd = 34'h2AAAAAAAA;
    exp1 = {pd[25:0], pc, pb, pa};
    add_beat({34'($urandom()), pa}, 34, 0);
    add_beat({34'($urandom()), pb}, 34, 0);
    add_beat({34'($urandom()), pc}, 34, 0);
    add_beat({34'($urandom()), pd}, 34, 0);
    run(100, 100, 0);
    check("t1_chunk_explicit", last_chunk, exp1);
    add_beat(rand68(), 0, 1);
    run(100, 100, 0);
    check("t1_residual_explicit", last_chunk, {120'd0, pd[33:26]});

    add_beat(rand68(), 64, 0);
    add_beat(rand68(), 64, 1);
    run(100, 100, 0);

    for (int k = 0; k < 3; k++) add_beat(rand68(), 68, k == 2);
    run(100, 100, 0);

    add_beat(rand68(), 0, 1);
    run(100, 100, 0);
    check("t4_zero_chunk", last_chunk, 0);

    // downstream stall with a beat of the next line waiting on the input
    add_beat(rand68(), 64, 0);
    add_beat(rand68(), 64, 1);
    add_rand_line();
    run(100, 100, 5);

    for (int k = 0; k < 60; k++) add_rand_line();
    run(70, 70, 0);

    // reset in FLUSH with 150 buffered bits
    push_beat(rand68(), 68, 0);
    push_beat(rand68(), 32, 0);
    push_beat(rand68(), 50, 1);
    check("flush_valid", o_valid, 1);
    check("flush_last", o_last, 0);
    check("flush_state", o_state, FLUSH);
    #2;
    i_reset = 0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_ready", o_ready, 1);
    check("arst_data", o_data, 0);
    check("arst_state", o_state, ACCUM);
    beat_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    exp_lb_q.delete();
    model_bits.delete();
    model_total = 0;
    #3;
    i_reset = 1;
    @(posedge i_clk);
    #1;
    add_beat(rand68(), 20, 0);
    add_beat(rand68(), 30, 1);
    run(100, 100, 0);
    add_rand_line();
    run(80, 80, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/compressed_line_packer.md
# compressed_line_packer

Downstream of the length-accumulation stage in the compression pipeline. Takes variable-length compressed codes, each up to 68 bits and LSB-aligned, with their bit lengths. Concatenates them LSB-first into a 256-bit staging buffer and emits dense 128-bit chunks over a valid/ready handshake. On the last beat of a cache line it flushes the remainder zero-padded and marks the final chunk.

## Interface
- IN_W, 68: input code width (two 34-bit max codes per beat)
- LEN_W, 7: length field width
- CHUNK, 128: output chunk width; buffer is 2*CHUNK
- CNT_W, 8: fill counter width (0..255)
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  packer can accept a beat
- i_data  in  IN_W  compressed code, LSB-aligned; bits at index >= i_len ignored
- i_len  in  LEN_W  code length in bits, legal 0..IN_W
- i_last  in  1  beat is the final beat of the current cache line
- o_valid  out  1  output chunk valid
- i_ready  in  1  downstream accepts chunk
- o_data  out  CHUNK  packed chunk; earliest-arriving bit at bit 0
- o_last  out  1  chunk is the final chunk of the line
- o_line_bits  out  10  total compressed bits of the line, valid with o_last (see Configuration)

## Operation
- State: buf[255:0], fill[CNT_W-1:0], line_bits[9:0], FSM {ACCUM, EMIT, FLUSH}.
- Invariant: buf bits at index >= fill are always zero. The input is masked to i_len bits before insertion.
- ACCUM: o_ready=1, o_valid=0. On i_valid&&o_ready:
  - buf |= masked(i_data) << fill; fill += i_len; line_bits += i_len.
  - If i_last -> FLUSH.
  - Else if new fill >= CHUNK -> EMIT.
  - Else stay in ACCUM.
- EMIT: o_ready=0, o_valid=1, o_data=buf[127:0], o_last=0. On i_ready: buf >>= 128, fill -= 128 -> ACCUM.
- FLUSH: o_ready=0, o_valid=1, o_data=buf[127:0], o_last=(fill<=CHUNK).
  - On i_ready with o_last: buf=0, fill=0, line_bits=0 -> ACCUM.
  - On i_ready without o_last: buf >>= 128, fill -= 128, stay in FLUSH.
- Every line produces at least one chunk. A last beat that leaves fill=0 emits one all-zero chunk with o_last=1.
- Overflow is impossible: a beat is accepted only in ACCUM with fill<128, so fill never exceeds 195.
- i_len > IN_W is illegal. The RTL saturates it to IN_W.

## Timing
- Reset values: state ACCUM, buf=0, fill=0, line_bits=0, o_ready=1, o_valid=0, o_data=0, o_last=0, o_line_bits=0.
- A beat accepted in cycle N that crosses 128 bits or carries i_last makes o_valid=1 in cycle N+1.
- Throughput: one beat per cycle while fill stays below 128. Each emitted chunk costs at least one bubble cycle on the input.
- o_data, o_last and o_line_bits come straight from registers and are stable while o_valid && !i_ready.
- Valid must not drop and data must not change until the handshake completes (AXI-stream rules, both directions).
- i_valid is ignored outside ACCUM, including in the cycle of an output handshake.
- Asynchronous reset mid-line discards the buffered bits and returns to ACCUM immediately. No partial chunk is emitted.

## Configuration
- PACKER_LINE_LEN_EN defined:
  - line_bits is kept as above.
  - o_line_bits = line_bits + i_len-accumulated total, presented with the o_last chunk.
  - o_line_bits holds 0 at all other times.
- PACKER_LINE_LEN_EN undefined:
  - The line_bits register is not built.
  - o_line_bits is tied to 0.
  - All other behaviour is identical.

## Structure
- packer_pkg holds:
  - the state enum typedef (ACCUM, EMIT, FLUSH)
  - constants IN_W, LEN_W, CHUNK, CNT_W
  - a localparam for buffer width 2*CHUNK
- One sub-module: packer_insert. It is combinational: masks i_data to i_len bits and barrel-shifts the result left by fill into a 256-bit vector.
- The top level holds the FSM, registers and handshake logic.

## Test plan
- Reset, then four beats of len=34 with patterns A..D, no i_last -> one chunk after the 4th beat: bits[33:0]=A, [67:34]=B, [101:68]=C, [127:102]=D[25:0], o_last=0. Residual fill=8.
- Two beats of len=64, the second with i_last -> exactly one chunk, o_last=1, o_line_bits=128. Fill returns to 0.
- Three beats of len=68, the third with i_last -> chunk 1 (o_last=0) carries bits 0..127. Chunk 2 (o_last=1) carries 76 bits, bits [127:76]=0, o_line_bits=204.
- Single beat len=0 with i_last -> one all-zero chunk, o_last=1, o_line_bits=0.
- Hold i_ready=0 for 5 cycles while o_valid=1 -> o_data stable, o_ready=0, input i_valid ignored. Chunk is transferred on the first i_ready=1.
- Assert reset while in FLUSH with fill=150 -> o_valid=0 and o_ready=1 in the same cycle. The next line's first chunk contains no stale bits.
